// File: rtl/csr_defs.sv
// csr_defs: CSR addresses, mstatus bit positions and sequencer state encoding.
package csr_defs;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI   = 12;
  localparam int MPP_LO   = 11;
  typedef enum logic [2:0] {
    IDLE,
    T_MEPC,
    T_MCAUSE,
    T_MTVAL,
    T_MSTATUS,
    M_MSTATUS,
    REDIRECT
  } state_e;
endpackage

// File: rtl/csr_trap_target.sv
// csr_trap_target: trap handler PC from mtvec, direct or vectored by interrupt cause.
module csr_trap_target #(
  parameter int XLEN   = 32,
  parameter bit VEC_EN = 1'b1
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic            irq,
  input  logic [3:0]      code,
  output logic [XLEN-1:0] target
);
  logic [XLEN-1:0] base;
  always_comb begin
    base   = {mtvec[XLEN-1:2], 2'b00};
    target = (VEC_EN && mtvec[1:0] == 2'b01 && irq) ? base + {{(XLEN-6){1'b0}}, code, 2'b00} : base;
  end
endmodule

// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: arbitrates the CSR write port between WB writebacks and the
// multi-cycle trap-entry / MRET update sequences, then redirects and flushes the pipe.
module csr_trap_sequencer
  import csr_defs::*;
#(
  parameter int XLEN   = 32,
  parameter bit VEC_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_req,
  input  logic            trap_irq,
  input  logic [3:0]      trap_code,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_req,
  input  logic            pipe_csr_we,
  input  logic [11:0]     pipe_csr_addr,
  input  logic [XLEN-1:0] pipe_csr_wdata,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic [XLEN-1:0] mstatus_in,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall_pipe,
  output logic            flush_pipe,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, cause_q, cause_d, tval_q, tval_d, target_q, target_d;
  logic [XLEN-1:0] trap_target, ms_trap, ms_mret;
  csr_trap_target #(.XLEN(XLEN), .VEC_EN(VEC_EN)) u_target (
    .mtvec  (mtvec_in),
    .irq    (trap_irq),
    .code   (trap_code),
    .target (trap_target)
  );
  // mstatus is read live in its write cycle; the pipeline is stalled so it cannot change.
  always_comb begin
    ms_trap                = mstatus_in;
    ms_trap[MPIE_BIT]      = mstatus_in[MIE_BIT];
    ms_trap[MIE_BIT]       = 1'b0;
    ms_trap[MPP_HI:MPP_LO] = 2'b11;
    ms_mret                = mstatus_in;
    ms_mret[MIE_BIT]       = mstatus_in[MPIE_BIT];
    ms_mret[MPIE_BIT]      = 1'b1;
    ms_mret[MPP_HI:MPP_LO] = 2'b11;
  end
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    tval_d         = tval_q;
    target_d       = target_q;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    flush_pipe     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        if (trap_req) begin
          pc_d     = trap_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
          cause_d  = {trap_irq, {(XLEN-5){1'b0}}, trap_code};
          tval_d   = trap_tval;
          target_d = trap_target;
          state_d  = T_MEPC;
        end else if (mret_req) begin
          target_d = mepc_in;
          state_d  = M_MSTATUS;
        end else if (pipe_csr_we) begin
          csr_we    = 1'b1;
          csr_waddr = pipe_csr_addr;
          csr_wdata = pipe_csr_wdata;
        end
      end
      T_MEPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = pc_q;
        state_d   = T_MCAUSE;
      end
      T_MCAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause_q;
        state_d   = T_MTVAL;
      end
      T_MTVAL: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = tval_q;
        state_d   = T_MSTATUS;
      end
      T_MSTATUS: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = ms_trap;
        state_d   = REDIRECT;
      end
      M_MSTATUS: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = ms_mret;
        state_d   = REDIRECT;
      end
      REDIRECT: begin
        flush_pipe     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy       = (state_q != IDLE);
  assign stall_pipe = busy;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      target_q <= target_d;
    end
  end
endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb_csr_trap_sequencer: vector table plus scoreboard queue of per-cycle expected outputs;
// a second instance with VEC_EN=0 checks the direct-mode redirect target.
module tb_csr_trap_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        trap_req, trap_irq, mret_req, pipe_csr_we;
  logic [3:0]  trap_code;
  logic [11:0] pipe_csr_addr;
  logic [31:0] trap_pc, trap_tval, pipe_csr_wdata, mtvec_in, mepc_in, mstatus_in;
  logic        csr_we, stall_pipe, flush_pipe, redirect_valid, busy;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;
  logic        d_we, d_stall, d_flush, d_rv, d_busy;
  logic [11:0] d_waddr;
  logic [31:0] d_wdata, d_rpc;
  always #5 clk = ~clk;
  csr_trap_sequencer #(.XLEN(32), .VEC_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .trap_req(trap_req), .trap_irq(trap_irq), .trap_code(trap_code),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_req(mret_req), .pipe_csr_we(pipe_csr_we),
    .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wdata(pipe_csr_wdata), .mtvec_in(mtvec_in),
    .mepc_in(mepc_in), .mstatus_in(mstatus_in), .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .stall_pipe(stall_pipe), .flush_pipe(flush_pipe),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );
  csr_trap_sequencer #(.XLEN(32), .VEC_EN(1'b0)) dut_d (
    .clk(clk), .rst(rst), .trap_req(trap_req), .trap_irq(trap_irq), .trap_code(trap_code),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_req(mret_req), .pipe_csr_we(pipe_csr_we),
    .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wdata(pipe_csr_wdata), .mtvec_in(mtvec_in),
    .mepc_in(mepc_in), .mstatus_in(mstatus_in), .csr_we(d_we), .csr_waddr(d_waddr),
    .csr_wdata(d_wdata), .stall_pipe(d_stall), .flush_pipe(d_flush),
    .redirect_valid(d_rv), .redirect_pc(d_rpc), .busy(d_busy)
  );
  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        stall, flush, rv;
    logic [31:0] rpc, rpc_d;
    logic        busy;
  } exp_t;
  typedef struct {
    logic        trap, irq;
    logic [3:0]  code;
    logic [31:0] pc, tval;
    logic        mret, pwe;
    logic [11:0] paddr;
    logic [31:0] pwdata, mtvec, mepc, mstatus, ms_exp, tgt, tgt_d;
  } vec_t;
  exp_t sbq[$];
  vec_t vt[9];
  int   n_vec = 0, n_mis = 0;
  function automatic exp_t ex(logic we, logic [11:0] a, logic [31:0] d, logic bsy, logic rv,
                              logic [31:0] p, logic [31:0] pd);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.stall = bsy; e.flush = rv; e.rv = rv;
    e.rpc = p; e.rpc_d = pd; e.busy = bsy;
    return e;
  endfunction
  task automatic check(input string nm);
    exp_t e, a;
    n_vec++;
    if (sbq.size() == 0) begin
      n_mis++;
      $display("FAIL %s: scoreboard empty, nothing expected", nm);
    end else begin
      e = sbq.pop_front();
      a.we = csr_we; a.addr = csr_waddr; a.data = csr_wdata; a.stall = stall_pipe;
      a.flush = flush_pipe; a.rv = redirect_valid; a.rpc = redirect_pc; a.rpc_d = d_rpc; a.busy = busy;
      if (a !== e) begin
        n_mis++;
        $display("FAIL %s: got we=%b addr=%h data=%h st=%b fl=%b rv=%b pc=%h pcd=%h busy=%b, want we=%b addr=%h data=%h st=%b fl=%b rv=%b pc=%h pcd=%h busy=%b",
                 nm, a.we, a.addr, a.data, a.stall, a.flush, a.rv, a.rpc, a.rpc_d, a.busy,
                 e.we, e.addr, e.data, e.stall, e.flush, e.rv, e.rpc, e.rpc_d, e.busy);
      end
    end
  endtask
  task automatic idle_in();
    trap_req = 0; trap_irq = 0; trap_code = 0; trap_pc = 0; trap_tval = 0; mret_req = 0;
    pipe_csr_we = 0; pipe_csr_addr = 0; pipe_csr_wdata = 0; mtvec_in = 0; mepc_in = 0;
  endtask
  // Everything except mstatus_in is scrambled while busy; none of it may be observed.
  task automatic noise();
    trap_req = 1; trap_irq = 1; trap_code = 4'hF; trap_pc = 32'hFFFF_FFFF; trap_tval = 32'h1;
    mret_req = 1; pipe_csr_we = 1; pipe_csr_addr = 12'h7FF; pipe_csr_wdata = 32'h5555_AAAA;
    mtvec_in = 32'hFFFF_FF01; mepc_in = 32'h4444_4444;
  endtask
  task automatic apply_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    trap_req = v.trap; trap_irq = v.irq; trap_code = v.code; trap_pc = v.pc; trap_tval = v.tval;
    mret_req = v.mret; pipe_csr_we = v.pwe; pipe_csr_addr = v.paddr; pipe_csr_wdata = v.pwdata;
    mtvec_in = v.mtvec; mepc_in = v.mepc; mstatus_in = v.mstatus;
    if (v.trap) begin
      sbq.push_back(ex(0, 0, 0, 0, 0, 0, 0));
      sbq.push_back(ex(1, 12'h341, v.pc & 32'hFFFF_FFFC, 1, 0, 0, 0));
      sbq.push_back(ex(1, 12'h342, {v.irq, 27'b0, v.code}, 1, 0, 0, 0));
      sbq.push_back(ex(1, 12'h343, v.tval, 1, 0, 0, 0));
      sbq.push_back(ex(1, 12'h300, v.ms_exp, 1, 0, 0, 0));
      sbq.push_back(ex(0, 0, 0, 1, 1, v.tgt, v.tgt_d));
    end else if (v.mret) begin
      sbq.push_back(ex(0, 0, 0, 0, 0, 0, 0));
      sbq.push_back(ex(1, 12'h300, v.ms_exp, 1, 0, 0, 0));
      sbq.push_back(ex(0, 0, 0, 1, 1, v.tgt, v.tgt_d));
    end else
      sbq.push_back(ex(v.pwe, v.pwe ? v.paddr : 12'h0, v.pwe ? v.pwdata : 32'h0, 0, 0, 0, 0));
    @(negedge clk);
    check($sformatf("v%0d.c0", idx));
    for (int c = 1; sbq.size() > 0; c++) begin
      @(posedge clk); #1;
      noise();
      @(negedge clk);
      check($sformatf("v%0d.c%0d", idx, c));
    end
  endtask
  initial begin
    vt[0] = '{0, 0, 0, 0, 0, 0, 1, 12'h340, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0};
    vt[1] = '{0, 0, 0, 0, 0, 0, 1, 12'h305, 32'h1234_5678, 0, 0, 0, 0, 0, 0};
    vt[2] = '{0, 0, 0, 0, 0, 0, 0, 12'h123, 32'h99, 32'h3, 32'h5, 32'h7, 0, 0, 0};
    vt[3] = '{1, 0, 4'h2, 32'h104, 32'h73, 0, 0, 0, 0, 32'h8000_0000, 0, 32'h8,
              32'h1880, 32'h8000_0000, 32'h8000_0000};
    vt[4] = '{1, 1, 4'h7, 32'h2000_0006, 0, 0, 0, 0, 0, 32'h8000_0001, 0, 0,
              32'h1800, 32'h8000_001C, 32'h8000_0000};
    vt[5] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h200, 32'h1880, 32'h1888, 32'h200, 32'h200};
    vt[6] = '{1, 0, 4'hB, 32'h300, 32'hFFFF_FFFF, 1, 1, 12'h340, 32'hDEAD_BEEF, 32'h1000_0001,
              32'h7777_0000, 32'h88, 32'h1880, 32'h1000_0000, 32'h1000_0000};
    vt[7] = '{0, 0, 0, 0, 0, 1, 1, 12'h341, 32'h1, 0, 32'h8000_0100, 32'h8, 32'h1880,
              32'h8000_0100, 32'h8000_0100};
    vt[8] = '{1, 1, 4'h3, 32'h8, 32'hABC, 0, 0, 0, 0, 32'h0000_0101, 0, 32'hFFFF_FFFF,
              32'hFFFF_FFF7, 32'h0000_010C, 32'h0000_0100};
    idle_in();
    mstatus_in = 0;
    #2;
    sbq.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    check("reset");
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 9; i++) apply_vec(vt[i], i);
    // Reset in the middle of a trap sequence, while mcause is being written.
    @(posedge clk); #1;
    idle_in();
    trap_req = 1; trap_code = 4'h2; trap_pc = 32'h104; trap_tval = 32'h73;
    mtvec_in = 32'h8000_0000; mstatus_in = 32'h8;
    sbq.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    sbq.push_back(ex(1, 12'h341, 32'h104, 1, 0, 0, 0));
    sbq.push_back(ex(1, 12'h342, 32'h2, 1, 0, 0, 0));
    @(negedge clk);
    check("rst_mid.accept");
    @(posedge clk); #1;
    idle_in();
    @(negedge clk);
    check("rst_mid.mepc");
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid.mcause");
    #1 rst = 1;
    #1;
    sbq.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    check("rst_mid.cleared");
    #1 rst = 0;
    @(posedge clk); #1;
    pipe_csr_we = 1; pipe_csr_addr = 12'h340; pipe_csr_wdata = 32'hCAFE_F00D;
    sbq.push_back(ex(1, 12'h340, 32'hCAFE_F00D, 0, 0, 0, 0));
    @(negedge clk);
    check("rst_mid.pipe_write");
    @(posedge clk); #1;
    idle_in();
    sbq.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("rst_mid.idle");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
